// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, data (LSB first), parity and stop bits.
// Drives the mux_4x1 select pair plus the data and parity bits.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TX_start,
  input  logic [DATA_WIDTH-1:0] TX_datain,
  output logic                  TX_busy,
  output logic                  TX_done,
  output logic                  s0,
  output logic                  s1,
  output logic                  DATA_BIT,
  output logic                  PARITY_BIT
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_s0, r_s1, r_busy, r_done, r_data_bit, r_parity_bit;
  logic                  w_s0_nxt, w_s1_nxt, w_busy_nxt, w_done_nxt;
  logic                  w_data_bit_nxt, w_parity_bit_nxt;
  logic                  w_bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_bit   <= 1'b0;
      r_parity_bit <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_s0         <= w_s0_nxt;
      r_s1         <= w_s1_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_data_bit   <= w_data_bit_nxt;
      r_parity_bit <= w_parity_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_shift_nxt      = r_shift;
    w_parity_bit_nxt = r_parity_bit;
    w_bit_end        = (r_cnt == CNT_LAST);

    if (r_state != IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + CW'(1);
    end

    case (r_state)
      IDLE: begin
        if (TX_start) begin
          w_shift_nxt      = TX_datain;
          w_parity_bit_nxt = (^TX_datain) ^ (PARITY_ODD != 0);
          w_cnt_nxt        = '0;
          w_idx_nxt        = '0;
          w_state_nxt      = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = PARITY;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are derived from the next state so the registered ports line up
    // with the state they describe, with no input-to-output combinational path.
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP) && (w_cnt_nxt == CNT_LAST);
    case (w_state_nxt)
      START:   {w_s0_nxt, w_s1_nxt} = 2'b00;
      DATA:    {w_s0_nxt, w_s1_nxt} = 2'b01;
      PARITY:  {w_s0_nxt, w_s1_nxt} = 2'b10;
      default: {w_s0_nxt, w_s1_nxt} = 2'b11;
    endcase
    w_data_bit_nxt = (w_state_nxt == DATA) ? w_shift_nxt[0] : r_data_bit;
  end

  assign TX_busy    = r_busy;
  assign TX_done    = r_done;
  assign s0         = r_s0;
  assign s1         = r_s1;
  assign DATA_BIT   = r_data_bit;
  assign PARITY_BIT = r_parity_bit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected per-cycle line/busy/done
// values are queued at stimulus time and compared cycle by cycle.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start = '0;
  logic [7:0] din [3];
  logic [2:0] busy, done, s0, s1, dbit, pbit;
  logic [1:0] sel = '0;
  logic       w_line, w_busy, w_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .TX_start(start[0]), .TX_datain(din[0]),
    .TX_busy(busy[0]), .TX_done(done[0]), .s0(s0[0]), .s1(s1[0]),
    .DATA_BIT(dbit[0]), .PARITY_BIT(pbit[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .TX_start(start[1]), .TX_datain(din[1]),
    .TX_busy(busy[1]), .TX_done(done[1]), .s0(s0[1]), .s1(s1[1]),
    .DATA_BIT(dbit[1]), .PARITY_BIT(pbit[1])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_WIDTH(5), .PARITY_ODD(0)) u_w5 (
    .clk(clk), .rst(rst), .TX_start(start[2]), .TX_datain(din[2][4:0]),
    .TX_busy(busy[2]), .TX_done(done[2]), .s0(s0[2]), .s1(s1[2]),
    .DATA_BIT(dbit[2]), .PARITY_BIT(pbit[2])
  );

  // Reference model of the mux_4x1 line stage.
  function automatic logic line_of(input logic a, input logic b, input logic d, input logic p);
    case ({a, b})
      2'b00:   return 1'b0;
      2'b01:   return d;
      2'b10:   return p;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    w_line = line_of(s0[sel], s1[sel], dbit[sel], pbit[sel]);
    w_busy = busy[sel];
    w_done = done[sel];
  end

  task automatic push_frame(input logic [7:0] data, input int width, input int cpb,
                            input logic odd, input int n_idle);
    logic par;
    par = odd;
    for (int k = 0; k < width; k++) par ^= data[k];
    for (int c = 0; c < cpb; c++) exp_q.push_back('{1'b0, 1'b1, 1'b0});
    for (int k = 0; k < width; k++)
      for (int c = 0; c < cpb; c++) exp_q.push_back('{data[k], 1'b1, 1'b0});
    for (int c = 0; c < cpb; c++) exp_q.push_back('{par, 1'b1, 1'b0});
    for (int c = 0; c < cpb; c++) exp_q.push_back('{1'b1, 1'b1, (c == cpb - 1)});
    for (int c = 0; c < n_idle; c++) exp_q.push_back('{1'b1, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) din[i] = '0;
    start = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({s0[i], s1[i], busy[i], done[i], dbit[i], pbit[i]} !== 6'b110000) begin
        failures++;
        $display("FAIL reset_state inst=%0d got s0s1/busy/done/dbit/pbit=%b%b%b%b%b%b want 110000",
                 i, s0[i], s1[i], busy[i], done[i], dbit[i], pbit[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int   cyc;
    sel = 2'd0;
    start[0] = 1'b1; din[0] = 8'hC3;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({s0[0], s1[0], busy[0], done[0], dbit[0], pbit[0]} !== 6'b110000) begin
      failures++;
      $display("FAIL midframe_reset got s0s1/busy/done/dbit/pbit=%b%b%b%b%b%b want 110000",
               s0[0], s1[0], busy[0], done[0], dbit[0], pbit[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_frame(8'h3C, 8, 4, 1'b0, 1);
    start[0] = 1'b1; din[0] = 8'h3C;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({w_line, w_busy, w_done} !== e) begin
        failures++;
        $display("FAIL post_reset_3c cyc=%0d got line/busy/done=%b%b%b want %b",
                 cyc, w_line, w_busy, w_done, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_even_frame();
    exp_t e;
    int   cyc;
    sel = 2'd0;
    push_frame(8'hA5, 8, 4, 1'b0, 1);
    start[0] = 1'b1; din[0] = 8'hA5;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({w_line, w_busy, w_done} !== e) begin
        failures++;
        $display("FAIL even_a5 cyc=%0d got line/busy/done=%b%b%b want %b",
                 cyc, w_line, w_busy, w_done, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_odd_parity();
    logic [7:0] vec [2];
    exp_t       e;
    int         cyc;
    vec[0] = 8'hA5;
    vec[1] = 8'h07;
    sel = 2'd1;
    for (int v = 0; v < 2; v++) begin
      push_frame(vec[v], 8, 4, 1'b1, 1);
      start[1] = 1'b1; din[1] = vec[v];
      @(negedge clk);
      start[1] = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        checks++;
        if ({w_line, w_busy, w_done} !== e) begin
          failures++;
          $display("FAIL odd_%h cyc=%0d got line/busy/done=%b%b%b want %b",
                   vec[v], cyc, w_line, w_busy, w_done, e);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   cyc;
    sel = 2'd0;
    push_frame(8'h00, 8, 4, 1'b0, 6);
    start[0] = 1'b1; din[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({w_line, w_busy, w_done} !== e) begin
        failures++;
        $display("FAIL busy_ignore cyc=%0d got line/busy/done=%b%b%b want %b",
                 cyc, w_line, w_busy, w_done, e);
      end
      if (cyc == 10) begin
        start[0] = 1'b1; din[0] = 8'hFF;
      end else begin
        start[0] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    sel = 2'd0;
    push_frame(8'h55, 8, 4, 1'b0, 1);
    push_frame(8'hAA, 8, 4, 1'b0, 2);
    start[0] = 1'b1; din[0] = 8'h55;
    @(negedge clk);
    din[0] = 8'hAA;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({w_line, w_busy, w_done} !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got line/busy/done=%b%b%b want %b",
                 cyc, w_line, w_busy, w_done, e);
      end
      if (cyc == 46) start[0] = 1'b0;
      @(negedge clk);
    end
    start[0] = 1'b0;
  endtask

  task automatic test_width5();
    exp_t e;
    int   cyc;
    sel = 2'd2;
    push_frame(8'h1F, 5, 2, 1'b0, 2);
    start[2] = 1'b1; din[2] = 8'h1F;
    @(negedge clk);
    start[2] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({w_line, w_busy, w_done} !== e) begin
        failures++;
        $display("FAIL width5_1f cyc=%0d got line/busy/done=%b%b%b want %b",
                 cyc, w_line, w_busy, w_done, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_even_frame();
    test_odd_parity();
    test_busy_ignore();
    test_back_to_back();
    test_width5();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
